// File: rtl/reu_dma_sequencer.sv
// rtl/reu_dma_sequencer.sv - REU DMA transfer sequencer: stash/fetch/swap/verify byte walker
module reu_dma_sequencer #(
    parameter int REU_AW = 19
) (
    input  logic              PHI2,
    input  logic              nRES,
    input  logic              Execute,
    input  logic              BA,
    input  logic [1:0]        TType,
    input  logic              Autoload,
    input  logic              FixC64,
    input  logic              FixREU,
    input  logic [15:0]       C64Base,
    input  logic [REU_AW-1:0] REUBase,
    input  logic [15:0]       LenBase,
    input  logic [7:0]        C64DIn,
    input  logic [7:0]        REUDIn,
    output logic              DMA,
    output logic              DMARW,
    output logic [15:0]       C64Addr,
    output logic [REU_AW-1:0] REUAddr,
    output logic [15:0]       LenCur,
    output logic [7:0]        C64DOut,
    output logic              RAMWR,
    output logic [7:0]        RAMWData,
    output logic              Busy,
    output logic              EOB,
    output logic              Fault,
    output logic              Reload
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        SWAPW = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] T_STASH  = 2'b00;
    localparam logic [1:0] T_FETCH  = 2'b01;
    localparam logic [1:0] T_SWAP   = 2'b10;
    localparam logic [1:0] T_VERIFY = 2'b11;

    state_t              state, state_n;
    logic [15:0]         c64_n, len_n;
    logic [REU_AW-1:0]   reu_n;
    logic [7:0]          hold_c64, hold_reu, hold_c64_n, hold_reu_n;
    logic                dma_n, busy_n, eob_n, fault_n, reload_n;
    logic                advance;

    // State, counters, swap holds and status pulses; reset aborts any transfer
    always_ff @(posedge PHI2) begin
        if (!nRES) begin
            state    <= IDLE;
            C64Addr  <= '0;
            REUAddr  <= '0;
            LenCur   <= '0;
            hold_c64 <= '0;
            hold_reu <= '0;
            DMA      <= 1'b0;
            Busy     <= 1'b0;
            EOB      <= 1'b0;
            Fault    <= 1'b0;
            Reload   <= 1'b0;
        end else begin
            state    <= state_n;
            C64Addr  <= c64_n;
            REUAddr  <= reu_n;
            LenCur   <= len_n;
            hold_c64 <= hold_c64_n;
            hold_reu <= hold_reu_n;
            DMA      <= dma_n;
            Busy     <= busy_n;
            EOB      <= eob_n;
            Fault    <= fault_n;
            Reload   <= reload_n;
        end
    end

    // Next-state, counter stepping and the combinational bus/RAM drive
    always_comb begin
        state_n    = state;
        c64_n      = C64Addr;
        reu_n      = REUAddr;
        len_n      = LenCur;
        hold_c64_n = hold_c64;
        hold_reu_n = hold_reu;
        dma_n      = DMA;
        busy_n     = Busy;
        eob_n      = 1'b0;
        fault_n    = 1'b0;
        reload_n   = 1'b0;
        advance    = 1'b0;
        DMARW      = 1'b1;
        C64DOut    = 8'h00;
        RAMWR      = 1'b0;
        RAMWData   = 8'h00;

        case (state)
            IDLE: begin
                if (Execute) begin
                    c64_n   = C64Base;
                    reu_n   = REUBase;
                    len_n   = LenBase;
                    dma_n   = 1'b1;
                    busy_n  = 1'b1;
                    state_n = XFER;
                end
            end
            XFER: begin
                case (TType)
                    T_STASH: begin
                        RAMWR    = BA;
                        RAMWData = C64DIn;
                        advance  = BA;
                    end
                    T_FETCH: begin
                        DMARW   = 1'b0;
                        C64DOut = REUDIn;
                        advance = BA;
                    end
                    T_SWAP: begin
                        // First half of a swap only captures both bytes
                        if (BA) begin
                            hold_c64_n = C64DIn;
                            hold_reu_n = REUDIn;
                            state_n    = SWAPW;
                        end
                    end
                    T_VERIFY: begin
                        advance = BA;
                        fault_n = BA && (C64DIn != REUDIn);
                    end
                    default: ;
                endcase
            end
            SWAPW: begin
                DMARW    = 1'b0;
                C64DOut  = hold_reu;
                RAMWR    = BA;
                RAMWData = hold_c64;
                advance  = BA;
                if (BA) begin
                    state_n = XFER;
                end
            end
            DONE: begin
                if (Autoload) begin
                    c64_n    = C64Base;
                    reu_n    = REUBase;
                    len_n    = LenBase;
                    reload_n = 1'b1;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Length 1 is the last byte; it stays 1 so software can see the block finished
        if (advance) begin
            if (!FixC64) begin
                c64_n = C64Addr + 16'd1;
            end
            if (!FixREU) begin
                reu_n = REUAddr + REU_AW'(1);
            end
            if (LenCur == 16'd1) begin
                eob_n   = 1'b1;
                state_n = DONE;
            end else begin
                len_n = LenCur - 16'd1;
            end
        end

        if (fault_n) begin
            state_n = DONE;
        end

        if ((state != DONE) && (state_n == DONE)) begin
            dma_n  = 1'b0;
            busy_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_reu_dma_sequencer.sv
// tb/tb_reu_dma_sequencer.sv - scoreboard bench for reu_dma_sequencer
module tb_reu_dma_sequencer;

    localparam int AW = 19;

    logic          phi2, nres, execute, ba, autoload, fix_c64, fix_reu;
    logic [1:0]    ttype;
    logic [15:0]   c64_base, len_base;
    logic [AW-1:0] reu_base;
    logic [7:0]    c64_din, reu_din;
    logic          dma, dmarw, ramwr, busy, eob, fault, reload;
    logic [15:0]   c64_addr, len_cur;
    logic [AW-1:0] reu_addr;
    logic [7:0]    c64_dout, ram_wdata;

    reu_dma_sequencer #(.REU_AW(AW)) dut (
        .PHI2(phi2), .nRES(nres), .Execute(execute), .BA(ba), .TType(ttype),
        .Autoload(autoload), .FixC64(fix_c64), .FixREU(fix_reu),
        .C64Base(c64_base), .REUBase(reu_base), .LenBase(len_base),
        .C64DIn(c64_din), .REUDIn(reu_din), .DMA(dma), .DMARW(dmarw),
        .C64Addr(c64_addr), .REUAddr(reu_addr), .LenCur(len_cur),
        .C64DOut(c64_dout), .RAMWR(ramwr), .RAMWData(ram_wdata),
        .Busy(busy), .EOB(eob), .Fault(fault), .Reload(reload)
    );

    typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } ram_ev_t;
    typedef struct packed { logic [15:0] a; logic [7:0] d; } c64_ev_t;
    typedef struct packed {
        logic eob; logic fault; logic [15:0] c; logic [AW-1:0] r; logic [15:0] l;
    } end_ev_t;

    ram_ev_t ram_q[$];
    c64_ev_t c64_q[$];
    end_ev_t end_q[$];

    logic [7:0] env_c64 [int unsigned];
    logic [7:0] env_reu [int unsigned];
    logic [7:0] mdl_c64 [int unsigned];
    logic [7:0] mdl_reu [int unsigned];

    int n_chk = 0;
    int n_fail = 0;

    initial begin
        phi2 = 1'b0;
        forever #5 phi2 = ~phi2;
    end

    function automatic logic [7:0] hash(input int unsigned a, input int unsigned salt);
        int unsigned h;
        h = (a * 32'd2654435761) ^ (salt * 32'd40503);
        return h[20:13];
    endfunction

    function automatic logic [7:0] rd_env_c64(input int unsigned a);
        if (env_c64.exists(a)) return env_c64[a];
        return hash(a, 1);
    endfunction
    function automatic logic [7:0] rd_env_reu(input int unsigned a);
        if (env_reu.exists(a)) return env_reu[a];
        return hash(a, 2);
    endfunction
    function automatic logic [7:0] rd_mdl_c64(input int unsigned a);
        if (mdl_c64.exists(a)) return mdl_c64[a];
        return hash(a, 1);
    endfunction
    function automatic logic [7:0] rd_mdl_reu(input int unsigned a);
        if (mdl_reu.exists(a)) return mdl_reu[a];
        return hash(a, 2);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic poke_c64(input int unsigned a, input logic [7:0] d);
        env_c64[a] = d;
        mdl_c64[a] = d;
    endtask
    task automatic poke_reu(input int unsigned a, input logic [7:0] d);
        env_reu[a] = d;
        mdl_reu[a] = d;
    endtask

    // Memories seen by the sequencer: refreshed after each edge from the current addresses
    always @(posedge phi2) begin
        #1;
        c64_din = rd_env_c64(32'(c64_addr));
        reu_din = rd_env_reu(32'(reu_addr));
    end

    // Monitor: pop and compare every RAM write, C64 write and end-of-block report
    always @(negedge phi2) begin
        ram_ev_t re;
        c64_ev_t ce;
        end_ev_t ee;
        if (ramwr) begin
            if (ram_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL ram_write_unexpected: got addr %0h data %0h required none", reu_addr, ram_wdata);
            end else begin
                re = ram_q.pop_front();
                chk("ram_addr", 64'(reu_addr), 64'(re.a));
                chk("ram_data", 64'(ram_wdata), 64'(re.d));
            end
            env_reu[32'(reu_addr)] = ram_wdata;
        end
        if (dma && !dmarw && ba) begin
            if (c64_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL c64_write_unexpected: got addr %0h data %0h required none", c64_addr, c64_dout);
            end else begin
                ce = c64_q.pop_front();
                chk("c64_addr", 64'(c64_addr), 64'(ce.a));
                chk("c64_data", 64'(c64_dout), 64'(ce.d));
            end
            env_c64[32'(c64_addr)] = c64_dout;
        end
        if (eob || fault) begin
            if (end_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL end_unexpected: got eob %0b fault %0b required none", eob, fault);
            end else begin
                ee = end_q.pop_front();
                chk("end_eob", 64'(eob), 64'(ee.eob));
                chk("end_fault", 64'(fault), 64'(ee.fault));
                chk("end_c64addr", 64'(c64_addr), 64'(ee.c));
                chk("end_reuaddr", 64'(reu_addr), 64'(ee.r));
                chk("end_lencur", 64'(len_cur), 64'(ee.l));
            end
        end
    end

    // Reference: walk the block byte by byte over the model memories
    task automatic model_xfer(input logic [1:0] tt, input logic fc, input logic fr,
                              input logic [15:0] cb, input logic [AW-1:0] rb, input logic [15:0] lb,
                              output logic [15:0] fin_c, output logic [AW-1:0] fin_r,
                              output logic [15:0] fin_l);
        int n, k;
        int unsigned ca, ra;
        logic [7:0] c, r;
        bit flt;
        end_ev_t ee;
        n = (lb == 16'd0) ? 65536 : int'(lb);
        k = 0;
        flt = 0;
        for (int i = 0; i < n; i++) begin
            ca = (32'(cb) + (fc ? 0 : i)) % 65536;
            ra = (32'(rb) + (fr ? 0 : i)) % (1 << AW);
            c = rd_mdl_c64(ca);
            r = rd_mdl_reu(ra);
            k = i + 1;
            if (tt == 2'b00) begin
                ram_q.push_back('{a: AW'(ra), d: c});
                mdl_reu[ra] = c;
            end else if (tt == 2'b01) begin
                c64_q.push_back('{a: 16'(ca), d: r});
                mdl_c64[ca] = r;
            end else if (tt == 2'b10) begin
                ram_q.push_back('{a: AW'(ra), d: c});
                c64_q.push_back('{a: 16'(ca), d: r});
                mdl_reu[ra] = c;
                mdl_c64[ca] = r;
            end else if (c != r) begin
                flt = 1;
                break;
            end
        end
        fin_c = 16'(32'(cb) + (fc ? 0 : k));
        fin_r = AW'(32'(rb) + (fr ? 0 : k));
        fin_l = (k == n) ? 16'd1 : 16'(n - k);
        ee.eob = (k == n);
        ee.fault = flt;
        ee.c = fin_c;
        ee.r = fin_r;
        ee.l = fin_l;
        end_q.push_back(ee);
    endtask

    task automatic resync();
        ram_q.delete();
        c64_q.delete();
        end_q.delete();
        mdl_c64 = env_c64;
        mdl_reu = env_reu;
    endtask

    task automatic pulse_reset();
        nres = 1'b0;
        execute = 1'b0;
        @(posedge phi2); #1;
        nres = 1'b1;
        ba = 1'b1;
        resync();
    endtask

    task automatic run_xfer(input logic [1:0] tt, input logic al, input logic fc, input logic fr,
                            input logic [15:0] cb, input logic [AW-1:0] rb, input logic [15:0] lb,
                            input bit rnd_ba, input int stall_at);
        logic [15:0] ec, el, sc, sl;
        logic [AW-1:0] er, sr;
        int n, budget;
        bit done;
        model_xfer(tt, fc, fr, cb, rb, lb, ec, er, el);
        n = (lb == 16'd0) ? 65536 : int'(lb);
        budget = (rnd_ba ? 10 : 2) * n + 20;
        ttype = tt; autoload = al; fix_c64 = fc; fix_reu = fr;
        c64_base = cb; reu_base = rb; len_base = lb; ba = 1'b1;
        execute = 1'b1;
        @(posedge phi2); #1;
        execute = 1'b0;
        chk("busy_start", 64'(busy), 64'd1);
        chk("dma_start", 64'(dma), 64'd1);
        done = 0;
        for (int c = 0; c < budget; c++) begin
            if (c == stall_at) begin
                sc = c64_addr; sr = reu_addr; sl = len_cur;
                ba = 1'b0;
                repeat (3) begin
                    @(posedge phi2); #1;
                    chk("stall_dma", 64'(dma), 64'd1);
                    chk("stall_c64addr", 64'(c64_addr), 64'(sc));
                    chk("stall_reuaddr", 64'(reu_addr), 64'(sr));
                    chk("stall_lencur", 64'(len_cur), 64'(sl));
                end
                ba = 1'b1;
            end
            if (rnd_ba) begin
                ba = ($urandom_range(0, 3) != 0);
                execute = ($urandom_range(0, 7) == 0);
            end
            @(posedge phi2); #1;
            if (!busy) begin
                done = 1;
                break;
            end
        end
        ba = 1'b1;
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL xfer_timeout: got busy %0b after %0d cycles required 0", busy, budget);
            pulse_reset();
            return;
        end
        chk("done_dma", 64'(dma), 64'd0);
        execute = 1'($urandom_range(0, 1));
        @(posedge phi2); #1;
        execute = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_dma", 64'(dma), 64'd0);
        chk("reload", 64'(reload), 64'(al));
        chk("final_c64addr", 64'(c64_addr), al ? 64'(cb) : 64'(ec));
        chk("final_reuaddr", 64'(reu_addr), al ? 64'(rb) : 64'(er));
        chk("final_lencur", 64'(len_cur), al ? 64'(lb) : 64'(el));
        chk("ram_q_left", 64'(ram_q.size()), 64'd0);
        chk("c64_q_left", 64'(c64_q.size()), 64'd0);
        chk("end_q_left", 64'(end_q.size()), 64'd0);
        resync();
    endtask

    initial begin
        logic [15:0] ec, el, cb;
        logic [AW-1:0] er, rb;
        logic [1:0] tt;
        int n, mm;
        int unsigned ca, ra;
        nres = 1'b0; execute = 1'b0; ba = 1'b1; ttype = 2'b00; autoload = 1'b0;
        fix_c64 = 1'b0; fix_reu = 1'b0; c64_base = 16'h0; reu_base = '0; len_base = 16'h0;
        c64_din = 8'h0; reu_din = 8'h0;
        repeat (2) @(posedge phi2);
        #1;
        chk("rst_dma", 64'(dma), 64'd0);
        chk("rst_dmarw", 64'(dmarw), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", 64'({eob, fault, reload, ramwr}), 64'd0);
        chk("rst_c64addr", 64'(c64_addr), 64'd0);
        chk("rst_reuaddr", 64'(reu_addr), 64'd0);
        chk("rst_lencur", 64'(len_cur), 64'd0);
        chk("rst_c64dout", 64'(c64_dout), 64'd0);
        nres = 1'b1;
        @(posedge phi2); #1;

        run_xfer(2'b00, 1'b0, 1'b0, 1'b0, 16'hC000, '0, 16'd3, 0, -1);
        run_xfer(2'b01, 1'b1, 1'b1, 1'b0, 16'hD020, '0, 16'd2, 0, -1);

        poke_c64(32'h1234, 8'h5A);
        poke_reu(32'h100, 8'hA5);
        run_xfer(2'b10, 1'b0, 1'b0, 1'b0, 16'h1234, AW'(32'h100), 16'd1, 0, -1);
        chk("swap_reu_byte", 64'(rd_env_reu(32'h100)), 64'h5A);
        chk("swap_c64_byte", 64'(rd_env_c64(32'h1234)), 64'hA5);

        for (int i = 0; i < 4; i++) begin
            poke_c64(32'h2000 + i, rd_mdl_reu(32'h300 + i) ^ ((i == 1) ? 8'h40 : 8'h00));
        end
        run_xfer(2'b11, 1'b0, 1'b0, 1'b0, 16'h2000, AW'(32'h300), 16'd4, 0, -1);

        run_xfer(2'b00, 1'b0, 1'b0, 1'b0, 16'h5000, AW'(32'h2000), 16'd6, 0, 2);

        model_xfer(2'b00, 1'b0, 1'b0, 16'h4000, AW'(32'h10), 16'd10, ec, er, el);
        ttype = 2'b00; autoload = 1'b0; fix_c64 = 1'b0; fix_reu = 1'b0;
        c64_base = 16'h4000; reu_base = AW'(32'h10); len_base = 16'd10;
        execute = 1'b1;
        @(posedge phi2); #1;
        execute = 1'b0;
        repeat (4) @(posedge phi2);
        #1;
        pulse_reset();
        chk("midrst_dma", 64'(dma), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_counters", 64'({c64_addr, len_cur}), 64'd0);
        chk("midrst_reuaddr", 64'(reu_addr), 64'd0);

        for (int t = 0; t < 20; t++) begin
            tt = 2'($urandom_range(0, 3));
            cb = 16'($urandom);
            rb = AW'($urandom);
            n = $urandom_range(1, 12);
            if (tt == 2'b11) begin
                mm = $urandom_range(0, n);
                for (int i = 0; i < n; i++) begin
                    ca = (32'(cb) + i) % 65536;
                    ra = (32'(rb) + i) % (1 << AW);
                    poke_c64(ca, rd_mdl_reu(ra) ^ ((i == mm) ? 8'h01 : 8'h00));
                end
                run_xfer(tt, 1'($urandom), 1'b0, 1'b0, cb, rb, 16'(n), 1, -1);
            end else begin
                run_xfer(tt, 1'($urandom), 1'($urandom), 1'($urandom), cb, rb, 16'(n), 1, -1);
            end
        end

        run_xfer(2'b00, 1'b0, 1'b0, 1'b0, 16'h0100, AW'(32'h7FFFF), 16'd0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
